// File: rtl/xbar_switch_allocator.sv
// -----------------------------------------------------------------------------
// xbar_switch_allocator
//
// Switch allocator for an IN_N x OUT_M wormhole crossbar. Each output keeps its
// own IDLE/LOCKED state, owner register and round-robin pointer. An IDLE output
// picks a head-carrying input, starting the search at its pointer. It then
// stays locked to that input until the packet's tail flit has crossed. The
// pointer then moves to the input after the owner, so inputs are served fairly.
// All parameters must be >= 2 so that the index fields are at least 1 bit wide.
//
// Ports
//   clk_i        : clock, all state updates on the rising edge
//   rst_ni       : asynchronous active-low reset
//   req_valid_i  : [IN_N]            input i has a flit at its buffer head
//   req_dst_i    : [IN_N*DST_W]      routed output index, slice i = input i
//   flit_id_i    : [IN_N*FLIT_ID_W]  head flit type, slice i = input i
//   out_ready_i  : [OUT_M]           output j can accept a flit this cycle
//   sel_o        : [OUT_M*SEL_W]     crossbar select, slice j = input for output j
//   out_valid_o  : [OUT_M]           output j carries a valid flit this cycle
//   in_pop_o     : [IN_N]            flit of input i consumed this cycle
// -----------------------------------------------------------------------------
module xbar_switch_allocator #(
  parameter int IN_N      = 5,
  parameter int OUT_M     = 5,
  parameter int FLIT_ID_W = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [IN_N-1:0]                   req_valid_i,
  input  logic [IN_N*$clog2(OUT_M)-1:0]     req_dst_i,
  input  logic [IN_N*FLIT_ID_W-1:0]         flit_id_i,
  input  logic [OUT_M-1:0]                  out_ready_i,
  output logic [OUT_M*$clog2(IN_N)-1:0]     sel_o,
  output logic [OUT_M-1:0]                  out_valid_o,
  output logic [IN_N-1:0]                   in_pop_o
);

  localparam int DST_W = $clog2(OUT_M);
  localparam int SEL_W = $clog2(IN_N);

  localparam logic [FLIT_ID_W-1:0] FID_BODY     = FLIT_ID_W'(2'b00);
  localparam logic [FLIT_ID_W-1:0] FID_TAIL     = FLIT_ID_W'(2'b01);
  localparam logic [FLIT_ID_W-1:0] FID_HEAD     = FLIT_ID_W'(2'b10);
  localparam logic [FLIT_ID_W-1:0] FID_HEADTAIL = FLIT_ID_W'(2'b11);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Per-input decode of the flit at each buffer head
  logic [DST_W-1:0] dst     [IN_N];
  logic [IN_N-1:0]  is_head;   // HEAD or HEADTAIL: may open a packet
  logic [IN_N-1:0]  is_tail;   // TAIL or HEADTAIL: closes a packet
  logic [IN_N-1:0]  is_body;   // HEAD or BODY: packet continues

  // Per-output results collected for the input-side pop OR
  logic [SEL_W-1:0] owner_w [OUT_M];
  logic [OUT_M-1:0] xfer;

  genvar gi;

  generate
    for (gi = 0; gi < IN_N; gi++) begin : g_in
      logic [FLIT_ID_W-1:0] fid;
      logic                 pop;

      assign dst[gi]     = req_dst_i[gi*DST_W +: DST_W];
      assign fid         = flit_id_i[gi*FLIT_ID_W +: FLIT_ID_W];
      assign is_head[gi] = (fid == FID_HEAD) || (fid == FID_HEADTAIL);
      assign is_tail[gi] = (fid == FID_TAIL) || (fid == FID_HEADTAIL);
      assign is_body[gi] = (fid == FID_HEAD) || (fid == FID_BODY);

      // The owner's destination selects a single output, so at most one term is set
      always_comb begin
        pop = 1'b0;
        for (int j = 0; j < OUT_M; j++) begin
          if (xfer[j] && (owner_w[j] == SEL_W'(gi))) begin
            pop = 1'b1;
          end
        end
      end

      assign in_pop_o[gi] = pop;
    end
  endgenerate

  generate
    for (gi = 0; gi < OUT_M; gi++) begin : g_out
      state_e           state_q, state_d;
      logic [SEL_W-1:0] owner_q, owner_d;
      logic [SEL_W-1:0] ptr_q, ptr_d;
      logic [IN_N-1:0]  elig;
      logic             found;
      logic [SEL_W-1:0] pick;

      // Inputs that hold a packet-opening flit routed to this output
      always_comb begin
        elig = '0;
        for (int i = 0; i < IN_N; i++) begin
          elig[i] = req_valid_i[i] && is_head[i] && (dst[i] == DST_W'(gi));
        end
      end

      // Round-robin pick: first eligible index at ptr, ptr+1, ... modulo IN_N
      always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < IN_N; k++) begin
          int unsigned idx;
          idx = int'(ptr_q) + k;
          if (idx >= IN_N) begin
            idx = idx - IN_N;
          end
          if (!found && elig[idx]) begin
            found = 1'b1;
            pick  = SEL_W'(idx);
          end
        end
      end

      // A flit crosses only from the owner, only when it is really routed here
      assign xfer[gi] = (state_q == LOCKED) && req_valid_i[owner_q] &&
                        (dst[owner_q] == DST_W'(gi)) && out_ready_i[gi];

      always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (state_q == IDLE) begin
          // out_ready_i plays no part here: the grant costs one cycle regardless
          if (found) begin
            state_d = LOCKED;
            owner_d = pick;
          end
        end else if (xfer[gi] && is_tail[owner_q]) begin
          state_d = IDLE;
          ptr_d   = (owner_q == SEL_W'(IN_N - 1)) ? '0 : owner_q + 1'b1;
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          state_q <= IDLE;
          owner_q <= '0;
          ptr_q   <= '0;
        end else begin
          state_q <= state_d;
          owner_q <= owner_d;
          ptr_q   <= ptr_d;
        end
      end

      assign owner_w[gi]                = owner_q;
      // Driven straight from the owner register so out_ready_i never reaches sel_o
      assign sel_o[gi*SEL_W +: SEL_W]   = owner_q;
      assign out_valid_o[gi]            = xfer[gi];
    end
  endgenerate

  // HEAD/BODY flits simply keep the lock; decoded only to document the encoding
  logic unused_body;
  assign unused_body = ^is_body;

endmodule

// File: doc/xbar_switch_allocator.md
XBAR_SWITCH_ALLOCATOR -- requirements
Module: xbar_switch_allocator

Interface
REQ-001 SHALL have parameter IN_N, default 5, number of input channels.
REQ-002 SHALL have parameter OUT_M, default 5, number of output channels.
REQ-003 SHALL have parameter FLIT_ID_W, default 2, flit ID width.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid_i  input  IN_N  input i holds a flit at its buffer head.
REQ-007 SHALL have port req_dst_i  input  IN_N*$clog2(OUT_M)  routed output index per input, slice i = input i.
REQ-008 SHALL have port flit_id_i  input  IN_N*FLIT_ID_W  flit type of head flit per input.
REQ-009 SHALL have port out_ready_i  input  OUT_M  downstream of output j can accept a flit this cycle.
REQ-010 SHALL have port sel_o  output  OUT_M*$clog2(IN_N)  crossbar select per output, slice j = input index routed to output j.
REQ-011 SHALL have port out_valid_o  output  OUT_M  output j carries a valid flit this cycle.
REQ-012 SHALL have port in_pop_o  output  IN_N  flit of input i consumed this cycle.

Function
REQ-013 SHALL decode flit_id: 2'b10 HEAD, 2'b00 BODY, 2'b01 TAIL, 2'b11 HEADTAIL (single-flit packet).
REQ-014 SHALL keep per output j: state {IDLE, LOCKED}, owner register, round-robin pointer ptr.
REQ-015 SHALL treat input i as eligible for output j when req_valid_i[i], req_dst_i slice i == j, and flit_id is HEAD or HEADTAIL.
REQ-016 SHALL, in IDLE with >=1 eligible input, pick the first eligible index scanning ptr, ptr+1, ... wrapping modulo IN_N, load owner, and enter LOCKED at the next edge; out_ready_i is not considered.
REQ-017 SHALL, in IDLE, drive out_valid_o[j]=0 and transfer nothing (1-cycle arbitration latency; first flit moves at earliest the cycle after the request).
REQ-018 SHALL, in LOCKED, assert out_valid_o[j] and in_pop_o[owner] combinationally iff req_valid_i[owner] && req_dst_i slice owner == j && out_ready_i[j].
REQ-019 SHALL, in LOCKED, hold state while no transfer occurs (valid low or ready low); no timeout.
REQ-020 SHALL, on a transfer whose flit_id is TAIL or HEADTAIL, return to IDLE at the next edge and set ptr = (owner+1) mod IN_N.
REQ-021 SHALL forward a HEAD or BODY flit from the owner in LOCKED as an ordinary flit without releasing the lock.
REQ-022 SHALL ignore requests from non-owner inputs to a LOCKED output; those inputs are not popped.
REQ-023 SHALL drive sel_o slice j = owner register in every state, so sel_o holds the last owner while IDLE.
REQ-024 SHALL compute in_pop_o[i] as OR over all outputs of the REQ-018 pop term; an input pops at most one flit per cycle.
REQ-025 SHALL operate each output independently, so up to min(IN_N,OUT_M) packets transfer in parallel.
REQ-026 SHALL, when a tail transfers while another head waits, arbitrate in the following IDLE cycle (one bubble cycle per packet boundary).
REQ-027 SHALL contain no combinational path from out_ready_i to sel_o.

Reset
REQ-028 SHALL, while rst_ni=0, force every output to IDLE and every owner and ptr to 0.
REQ-029 SHALL, during and after reset, drive sel_o=0, out_valid_o=0, in_pop_o=0 until a grant occurs.
REQ-030 SHALL abandon any partially transferred packet on mid-packet reset; no flit is popped on the release cycle.

Verification
REQ-031 SHALL pass: input 2 sends HEAD,BODY,TAIL to output 3, out_ready_i all 1 -> grant at cycle 1, out_valid_o[3] and in_pop_o[2] high cycles 2-4, sel_o slice 3 = 2, IDLE at cycle 5.
REQ-032 SHALL pass: inputs 0,1,4 each send HEADTAIL to output 0 continuously -> service order 0,1,4,0, each packet 2 cycles.
REQ-033 SHALL pass: input 1 locks output 2, input 3 sends HEAD to output 2 mid-packet -> input 3 not popped until input 1 tail transferred, granted the following cycle.
REQ-034 SHALL pass: out_ready_i[4] low 3 cycles mid-packet from input 0 -> no pop, out_valid_o[4]=0, lock held, resumes with the next BODY.
REQ-035 SHALL pass: inputs 0->1, 1->2, 2->3, 3->4, 4->0 concurrent HEADTAIL -> all five outputs valid in the same cycle, in_pop_o=5'b11111.
REQ-036 SHALL pass: rst_ni low after BODY flit of a 4-flit packet -> all outputs 0 asynchronously, next HEAD re-arbitrated from ptr 0.
